// File: rtl/mult_controller_pkg.sv
// Shared constants for the shift-add multiplier: state encodings, default width, mux selects.
package mult_controller_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_SHIFT = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_controller_iter_counter.sv
// Iteration counter for the multiplier FSM: synchronous clear, increment enable,
// saturates at WIDTH-1 and flags that terminal value.
module mult_iter_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sync_clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  // Holding at LAST_VAL keeps the count meaningful if the FSM lingers in RUN.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST_VAL)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/mult_controller.sv
// Control FSM for the shift-add multiplier datapath: load, WIDTH add/shift steps, done pulse.
// Optional MULT_EARLY_EXIT_EN leaves RUN as soon as the datapath reports B==0.
module mult_controller
  import mult_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic zero,
  input  logic lsb_b,
  output logic en_a,
  output logic ld_shift_a,
  output logic en_b,
  output logic ld_shift_b,
  output logic en_p,
  output logic ld_add_p,
  output logic ready,
  output logic busy,
  output logic done
);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             cnt_clr, cnt_inc;

  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  mult_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter_counter (
    .clk      (clk),
    .clr      (clr),
    .sync_clr (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .last     (last)
  );

`ifndef MULT_EARLY_EXIT_EN
  logic [CNT_W:0] unused_early_exit;
  assign unused_early_exit = {zero, cnt};
`endif

  always_comb begin
    next_state = state;
    en_a       = 1'b0;
    ld_shift_a = SEL_LOAD;
    en_b       = 1'b0;
    ld_shift_b = SEL_LOAD;
    en_p       = 1'b0;
    ld_add_p   = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = INIT;
      end
      INIT: begin
        busy    = 1'b1;
        en_a    = 1'b1;
        en_b    = 1'b1;
        en_p    = 1'b1;
        cnt_clr = 1'b1;
        next_state = RUN;
      end
      // Add uses the pre-shift A, so accumulate and shift happen on the same edge.
      RUN: begin
        busy       = 1'b1;
        en_a       = 1'b1;
        ld_shift_a = SEL_SHIFT;
        en_b       = 1'b1;
        ld_shift_b = SEL_SHIFT;
        en_p       = lsb_b;
        ld_add_p   = 1'b1;
        cnt_inc    = 1'b1;
        if (last) next_state = LATCH;
`ifdef MULT_EARLY_EXIT_EN
        // zero is registered, so at cnt==0 it still describes B from before the load.
        else if (zero && (cnt != '0)) next_state = LATCH;
`endif
      end
      LATCH: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller: behavioural datapath, scoreboard of expected
// products/done cycles, and a monitor that compares whenever the controller reports done.
module tb_mult_controller;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic zero, lsb_b;
  logic en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p;
  logic ready, busy, done;

  logic [3:0] a_in = 4'd0;
  logic [3:0] b_in = 4'd0;
  logic [7:0] reg_a = 8'd0;
  logic [3:0] reg_b = 4'd0;
  logic [7:0] p_out = 8'd0;
  logic       zero_r = 1'b0;

  always #5 clk = ~clk;

  mult_controller #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .zero       (zero),
    .lsb_b      (lsb_b),
    .en_a       (en_a),
    .ld_shift_a (ld_shift_a),
    .en_b       (en_b),
    .ld_shift_b (ld_shift_b),
    .en_p       (en_p),
    .ld_add_p   (ld_add_p),
    .ready      (ready),
    .busy       (busy),
    .done       (done)
  );

  // Datapath the controller steers: A shifts left, B shifts right, P accumulates.
  always @(posedge clk) begin
    if (en_a) reg_a <= ld_shift_a ? (reg_a << 1) : {4'd0, a_in};
    if (en_b) reg_b <= ld_shift_b ? (reg_b >> 1) : b_in;
    if (en_p) p_out <= ld_add_p ? (p_out + reg_a) : 8'd0;
    zero_r <= (reg_b == 4'd0);
  end
  assign zero  = zero_r;
  assign lsb_b = reg_b[0];

  typedef struct {
    int         acc;
    int         done_cyc;
    int         runs;
    logic [7:0] prod;
    logic [3:0] b;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int free_cyc = 0;
  int accept_cnt = 0;
  int abandon_cnt = 0;
  int done_cnt = 0;
  int checks = 0;
  int errors = 0;
  bit reset_seen = 1'b0;
  logic [3:0] enp_seen = 4'd0;

  // Number of RUN cycles: WIDTH normally; with early exit, stop once B has shifted to zero
  // and the registered flag has caught up (never before the second RUN cycle).
  function automatic int runsFor(input logic [3:0] b);
    int r;
    r = WIDTH;
`ifdef MULT_EARLY_EXIT_EN
    begin
      int bl;
      bl = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) bl = i + 1;
      r = bl + 2;
      if (r > WIDTH) r = WIDTH;
    end
`else
    if (b == 4'hF) r = WIDTH;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: decides acceptance from the request/availability rules alone.
  always @(posedge clk) begin
    exp_t e;
    if (!clr) begin
      abandon_cnt += q.size();
      q.delete();
      free_cyc   = cyc + 1;
      reset_seen = 1'b1;
    end else if (start && reset_seen && (cyc >= free_cyc)) begin
      e.acc      = cyc;
      e.runs     = runsFor(b_in);
      e.done_cyc = cyc + e.runs + 3;
      e.prod     = 8'(a_in) * 8'(b_in);
      e.b        = b_in;
      q.push_back(e);
      free_cyc   = e.done_cyc + 1;
      accept_cnt++;
    end
    cyc++;
  end

  // Monitor: status outputs every cycle, product and en_p history whenever done appears.
  always @(negedge clk) begin
    bit exp_ready, exp_done;
    int k;
    if (reset_seen) begin
      exp_ready = (cyc >= free_cyc);
      exp_done  = (q.size() > 0) && (q[0].done_cyc == cyc);
      checkOutput("ready", int'(ready), int'(exp_ready));
      checkOutput("busy", int'(busy), int'(!exp_ready && !exp_done));
      checkOutput("done", int'(done), int'(exp_done));
      if (exp_ready || exp_done)
        checkOutput("idle_ctrl", int'({en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p}), 0);
      if (done) done_cnt++;
      if (q.size() > 0) begin
        k = cyc - q[0].acc - 2;
        if (k >= 0 && k < q[0].runs) enp_seen[k] = en_p;
      end
      if (exp_done) begin
        checkOutput("p_out", int'(p_out), int'(q[0].prod));
        checkOutput("en_p_pattern", int'(enp_seen & 4'((1 << q[0].runs) - 1)),
                    int'(q[0].b & 4'((1 << q[0].runs) - 1)));
        enp_seen = 4'd0;
        void'(q.pop_front());
      end
    end
  end

  task automatic waitDrain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain", q.size(), 0);
    if (q.size() != 0) q.delete();
  endtask

  // Holds start until the model accepts, then releases it; operands stay put.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit drain);
    int n0, n;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    n0 = accept_cnt;
    n  = 0;
    while (accept_cnt == n0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("accepted", int'(accept_cnt != n0), 1);
    if (drain) waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(4'd6, 4'd7, 1'b1);
    applyStimulus(4'd15, 4'd15, 1'b1);
    applyStimulus(4'd0, 4'd9, 1'b1);
    applyStimulus(4'd7, 4'd0, 1'b1);
    applyStimulus(4'd9, 4'd1, 1'b1);

    // Start held high across several runs: each IDLE acceptance yields one done.
    @(negedge clk);
    a_in  = 4'd5;
    b_in  = 4'd11;
    start = 1'b1;
    repeat (25) @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Back-to-back: second request is raised during DONE and taken in the next IDLE.
    @(negedge clk);
    applyStimulus(4'd3, 4'd5, 1'b1);
    applyStimulus(4'd2, 4'd4, 1'b1);

    // Reset mid-RUN abandons the product; next multiply must still be correct.
    @(negedge clk);
    applyStimulus(4'd9, 4'd13, 1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    waitDrain();
    applyStimulus(4'd7, 4'd3, 1'b1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    end

    repeat (4) @(negedge clk);
    checkOutput("done_count", done_cnt, accept_cnt - abandon_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
